// File: rtl/fsm_out_tracer.sv
// Change-triggered trace FIFO for the controller's nine output lines; logs {ts, word}.
// Optional build macro FSM_TRACE_ZERO_SKIP_EN suppresses logging of changes to the all-zero word.
module fsm_out_tracer #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [8:0]               y_in,
    input  logic                     clr_ovf,
    input  logic                     rd_en,
    output logic [TS_W+8:0]          rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = TS_W + 9;

    logic [8:0]      y_q;
    logic            first;
    logic [TS_W-1:0] ts;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [EW-1:0]   mem [DEPTH];

    logic changed;
    logic capture;
    logic pop;
    logic push;
    logic drop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        changed = first || (y_in != y_q);
`ifdef FSM_TRACE_ZERO_SKIP_EN
        // the very first sample is always logged, even when it is zero
        capture = en && (first || (changed && (y_in != 9'h000)));
`else
        capture = en && changed;
`endif
        pop  = rd_en && !empty;
        // a simultaneous pop frees the slot, so a full FIFO can still accept
        push = capture && (!full || pop);
        drop = capture && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q      <= '0;
            first    <= 1'b1;
            ts       <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (en) begin
                ts    <= ts + TS_W'(1);
                y_q   <= y_in;
                first <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_valid <= pop;
            if (pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // storage needs no reset: pointers and count define what is live
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= {ts, y_in};
        end
    end

endmodule
